lane_queue_tracker: RTL and testbench



---
 rtl/traffic_pkg.sv | 14 +
 rtl/lane_counter.sv | 61 ++++++
 rtl/lane_queue_tracker.sv | 40 ++++
 tb/tb_lane_queue_tracker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lane indices, lane count and per-lane light state for the queue tracker.
package traffic_pkg;
  localparam int LANE_N1 = 0;
  localparam int LANE_N2 = 1;
  localparam int LANE_E1 = 2;
  localparam int LANE_E2 = 3;
  localparam int LANE_S1 = 4;
  localparam int LANE_S2 = 5;
  localparam int LANE_W1 = 6;
  localparam int LANE_W2 = 7;
  localparam int NUM_LANES = 8;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {RED, START, FLOW} lane_state_t;
endpackage

// File: rtl/lane_counter.sv
// lane_counter: one lane's saturating queue count with arrival edge detect and green start-up delay.
// Ports: clk, rst (sync, active-high), arrive (level sensor), green (light enable),
// tick (phase timer pulse), count (queue length), overflow (sticky, only with TRAFFIC_LANE_OVERFLOW_EN).
module lane_counter import traffic_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int START_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arrive,
  input  logic             green,
  input  logic             tick,
  output logic [CNT_W-1:0] count
`ifdef TRAFFIC_LANE_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int SW = $clog2(START_TICKS + 2);
  localparam logic [SW-1:0] LOAD = SW'(START_TICKS);
  lane_state_t state, stateNext;
  logic [SW-1:0] startCnt, startNext;
  logic arrivePrev, arrEdge, dep, full;
  assign arrEdge = arrive & ~arrivePrev;
  assign full = &count;
  assign dep = (state == FLOW) && tick && (count != '0);
  // A tick in the cycle green rises sees RED and is ignored; the tick that
  // empties the start counter only promotes to FLOW without a departure.
  always_comb begin
    stateNext = state;
    startNext = startCnt;
    if (!green) stateNext = RED;
    else if (state == RED) begin
      stateNext = (START_TICKS == 0) ? FLOW : START;
      startNext = LOAD;
    end else if (state == START && tick) begin
      startNext = startCnt - 1'b1;
      stateNext = (startCnt == SW'(1)) ? FLOW : START;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RED;
      startCnt <= '0;
      arrivePrev <= 1'b0;
      count <= '0;
    end else begin
      state <= stateNext;
      startCnt <= startNext;
      arrivePrev <= arrive;
      count <= (arrEdge && !dep && !full) ? count + 1'b1 :
               (dep && !arrEdge) ? count - 1'b1 : count;
    end
  end
`ifdef TRAFFIC_LANE_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (arrEdge && full && !dep) overflow <= 1'b1;
  end
`endif
endmodule

// File: rtl/lane_queue_tracker.sv
// lane_queue_tracker: eight independent lane queue counters plus their combined total.
// Ports: clk, rst (sync, active-high), arrive[7:0] / green[7:0] (bit0 N1 .. bit7 W2), tick,
// lane[7:0][CNT_W-1:0] per-lane counts, totalCars sum of counts,
// overflow[7:0] sticky saturation flags (only with TRAFFIC_LANE_OVERFLOW_EN).
module lane_queue_tracker import traffic_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int START_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            arrive,
  input  logic [7:0]            green,
  input  logic                  tick,
  output logic [7:0][CNT_W-1:0] lane,
  output logic [CNT_W+2:0]      totalCars
`ifdef TRAFFIC_LANE_OVERFLOW_EN
  ,
  output logic [7:0]            overflow
`endif
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    lane_counter #(.CNT_W(CNT_W), .START_TICKS(START_TICKS)) uLane (
      .clk(clk),
      .rst(rst),
      .arrive(arrive[i]),
      .green(green[i]),
      .tick(tick),
      .count(lane[i])
`ifdef TRAFFIC_LANE_OVERFLOW_EN
      ,
      .overflow(overflow[i])
`endif
    );
  end
  // Eight lanes at full scale need only three extra bits, so the sum never wraps.
  always_comb begin
    totalCars = '0;
    for (int k = 0; k < NUM_LANES; k++) totalCars = totalCars + (CNT_W+3)'(lane[k]);
  end
endmodule

// File: tb/tb_lane_queue_tracker.sv
// tb_lane_queue_tracker: directed and randomized checks of lane_queue_tracker against a queue model.
module tb_lane_queue_tracker;
  localparam int ST = 1;
  localparam int MAXC = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] arrive = '0;
  logic [7:0] green = '0;
  logic tick = 1'b0;
  logic [7:0][7:0] lane;
  logic [10:0] totalCars;
`ifdef TRAFFIC_LANE_OVERFLOW_EN
  logic [7:0] overflow;
`endif
  int checks = 0;
  int errors = 0;
  bit chkEn = 0;
  int mCnt[8];
  int mTicks[8];
  bit mPrevA[8];
  bit mPrevG[8];
  bit mOvf[8];

  lane_queue_tracker #(.CNT_W(8), .START_TICKS(ST)) dut (
    .clk(clk),
    .rst(rst),
    .arrive(arrive),
    .green(green),
    .tick(tick),
    .lane(lane),
    .totalCars(totalCars)
`ifdef TRAFFIC_LANE_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue model: a lane departs on a tick once green has been held for at
  // least one full cycle and ST ticks have already passed since then.
  task automatic modelUpdate();
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        mCnt[i] = 0; mTicks[i] = 0; mPrevA[i] = 0; mPrevG[i] = 0; mOvf[i] = 0;
      end else begin
        bit e, d;
        e = arrive[i] && !mPrevA[i];
        d = mPrevG[i] && tick && mCnt[i] > 0 && mTicks[i] >= ST;
        if (e && !d) begin
          if (mCnt[i] == MAXC) mOvf[i] = 1;
          else mCnt[i]++;
        end else if (d && !e) mCnt[i]--;
        if (!green[i]) mTicks[i] = 0;
        else if (mPrevG[i] && tick && mTicks[i] < 1000) mTicks[i]++;
        mPrevA[i] = arrive[i];
        mPrevG[i] = green[i];
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] g, input logic t);
    rst = r; arrive = a; green = g; tick = t;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      int sum;
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("model lane%0d", i), int'(lane[i]), mCnt[i]);
        sum += mCnt[i];
      end
      chk("model totalCars", int'(totalCars), sum);
`ifdef TRAFFIC_LANE_OVERFLOW_EN
      for (int i = 0; i < 8; i++) chk($sformatf("model overflow%0d", i), int'(overflow[i]), int'(mOvf[i]));
`endif
    end
  end

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0);
    chkEn = 1;
    chk("reset total", int'(totalCars), 0);
    chk("reset lane0", int'(lane[0]), 0);
    // held sensor counts once
    for (int k = 0; k < 5; k++) begin
      step(0, 8'h01, 0, 0);
      chk("held lane0", int'(lane[0]), 1);
      chk("held total", int'(totalCars), 1);
    end
    // start-up delay on lane 2
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 8'h04, 0, 0);
      step(0, 8'h00, 0, 0);
    end
    step(0, 0, 8'h04, 1);
    chk("rise tick lane2", int'(lane[2]), 3);
    step(0, 0, 8'h04, 1);
    chk("tick1 lane2", int'(lane[2]), 3);
    step(0, 0, 8'h04, 1);
    chk("tick2 lane2", int'(lane[2]), 2);
    step(0, 0, 8'h04, 1);
    chk("tick3 lane2", int'(lane[2]), 1);
    step(0, 0, 8'h04, 1);
    chk("tick4 lane2", int'(lane[2]), 0);
    step(0, 0, 8'h04, 1);
    chk("tick5 lane2", int'(lane[2]), 0);
    // simultaneous arrival and departure on lane 4
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 8'h10, 0, 0);
      step(0, 8'h00, 0, 0);
    end
    step(0, 0, 8'h10, 0);
    step(0, 0, 8'h10, 1);
    chk("flow entry lane4", int'(lane[4]), 5);
    step(0, 8'h10, 8'h10, 1);
    chk("arr+dep lane4", int'(lane[4]), 5);
    step(0, 0, 8'h10, 1);
    chk("dep lane4", int'(lane[4]), 4);
    // saturation on lane 7
    step(1, 0, 0, 0);
    for (int k = 1; k <= 260; k++) begin
      step(0, 8'h80, 0, 0);
      step(0, 8'h00, 0, 0);
`ifdef TRAFFIC_LANE_OVERFLOW_EN
      if (k == 255) chk("ovf before lane7", int'(overflow[7]), 0);
      if (k == 256) chk("ovf after lane7", int'(overflow[7]), 1);
`endif
    end
    chk("sat lane7", int'(lane[7]), 255);
    chk("sat total", int'(totalCars), 255);
    step(1, 0, 0, 0);
    chk("sat rst lane7", int'(lane[7]), 0);
`ifdef TRAFFIC_LANE_OVERFLOW_EN
    chk("ovf rst lane7", int'(overflow[7]), 0);
`endif
    // green drop during start-up on lane 6
    for (int k = 0; k < 4; k++) begin
      step(0, 8'h40, 0, 0);
      step(0, 8'h00, 0, 0);
    end
    step(0, 0, 8'h40, 0);
    step(0, 0, 8'h00, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1);
    chk("drop lane6", int'(lane[6]), 4);
    step(0, 0, 8'h40, 0);
    step(0, 0, 8'h40, 1);
    chk("restart lane6", int'(lane[6]), 4);
    step(0, 0, 0, 0);
    // reset mid-operation
    step(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] m;
      for (int i = 0; i < 8; i++) m[i] = (9 - i) > k;
      step(0, m, 0, 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("fill lane%0d", i), int'(lane[i]), 9 - i);
    chk("fill total", int'(totalCars), 44);
    step(0, 8'h0F, 0, 0);
    step(1, 8'hF0, 0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst lane%0d", i), int'(lane[i]), 0);
    chk("midrst total", int'(totalCars), 0);
    // randomized traffic
    begin
      logic [7:0] g;
      g = '0;
      for (int n = 0; n < 4000; n++) begin
        for (int i = 0; i < 8; i++) if ($urandom_range(15) == 0) g[i] = ~g[i];
        step($urandom_range(799) == 0, 8'($urandom & $urandom & $urandom), g,
             $urandom_range(2) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
